uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter ACT_TIMEOUT, default 4, meaning the clocks allowed from o_Tx_DV until i_Tx_Active before the byte is abandoned.
REQ-003 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_Req  input  N_REQ  per-requester byte-pending flag.
REQ-006 SHALL have port i_Req_Byte  input  8*N_REQ  per-requester byte; requester k owns bits [8k+7:8k].
REQ-007 SHALL have port i_Lock  input  N_REQ  per-requester request to keep the grant for the next byte (multi-byte message).
REQ-008 SHALL have port o_Ack  output  N_REQ  one-clock pulse; the byte is accepted and the requester may change it or drop i_Req next clock.
REQ-009 SHALL have port o_Grant  output  N_REQ  one-hot current owner, all-zero when idle.
REQ-010 SHALL have port o_Tx_DV  output  1  one-clock start pulse to the UART transmitter.
REQ-011 SHALL have port o_Tx_Byte  output  8  byte to transmit, stable from grant until release.
REQ-012 SHALL have port i_Tx_Active  input  1  transmitter busy flag.
REQ-013 SHALL have port i_Tx_Done  input  1  transmitter completion flag; may stay high for more than one clock.
REQ-014 SHALL have port o_Busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_Err  output  1  one-clock pulse on an ACT_TIMEOUT expiry.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_ACT, WAIT_DONE and RELEASE.
REQ-017 IDLE with any i_Req high SHALL, in that clock, pick the winner round-robin starting at last_owner+1 (wrapping at N_REQ), register o_Grant, latch the winner's byte into o_Tx_Byte and go to ISSUE.
REQ-018 ISSUE SHALL assert o_Tx_DV and o_Ack[owner] for exactly one clock, clear the timeout counter and go to WAIT_ACT; the latency from i_Req sampled in IDLE to o_Tx_DV SHALL be 1 clock.
REQ-019 WAIT_ACT SHALL go to WAIT_DONE when i_Tx_Active=1; after ACT_TIMEOUT clocks without it, SHALL pulse o_Err, clear o_Grant, set last_owner=owner and go to IDLE.
REQ-020 WAIT_DONE SHALL go to RELEASE on the first clock with i_Tx_Done=1.
REQ-021 RELEASE SHALL hold until i_Tx_Done=0, so that a multi-clock Done pulse is counted once.
REQ-022 RELEASE exit, when i_Lock[owner] and i_Req[owner] are both high, SHALL keep the grant, latch the owner's new byte and go to ISSUE; otherwise it SHALL set last_owner=owner, clear o_Grant and go to IDLE.
REQ-023 The byte SHALL be latched at grant; if the requester drops i_Req after the grant, transmission and o_Ack SHALL still complete.
REQ-024 i_Req from non-owners SHALL be ignored outside IDLE and RELEASE exit; no request SHALL be lost, and each requester waits at most N_REQ-1 grants when none hold i_Lock.
REQ-025 The round-robin pointer SHALL be clog2(N_REQ) bits, wrapping from N_REQ-1 to 0.

Reset
REQ-026 Asserting i_Rst_n low SHALL immediately force IDLE and set o_Ack, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err and the timeout counter to 0, and last_owner to N_REQ-1, so requester 0 has first priority.
REQ-027 Reset during any non-IDLE state SHALL abandon the byte without o_Ack and without a later o_Err.

Structure
REQ-028 A shared package/header uart_pkg SHALL hold the state encodings, N_REQ and ACT_TIMEOUT defaults, and the CLKS_PER_BIT constant for the 27 MHz / 115200 setting (234).
REQ-029 A sub-module rr_pick SHALL implement the combinational round-robin priority encoder (inputs: req vector and pointer; outputs: one-hot grant and valid).

Verification
REQ-030 Bench with uart_tx at CLKS_PER_BIT=4: i_Req=0001, byte 0x55 -> o_Tx_DV one clock later, o_Ack=0001 in the same clock, serial 0x55 observed, then IDLE with o_Grant=0000.
REQ-031 i_Req=1111 held, bytes 0xA0..0xA3 -> grants in the order 0,1,2,3,0, with exactly one o_Ack per byte.
REQ-032 Requester 2 sends 3 bytes with i_Lock=1 while i_Req=1011 -> 3 consecutive grants to 2, then rotation to 3 and then 0.
REQ-033 i_Tx_Active tied low -> o_Err pulses ACT_TIMEOUT clocks after o_Tx_DV, then IDLE, and the next requester is served.
REQ-034 i_Tx_Done held high for 2 clocks -> exactly one RELEASE exit and no duplicate o_Tx_DV.
REQ-035 i_Rst_n pulsed low during WAIT_DONE -> all outputs 0 asynchronously, and the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and default settings.
package uart_pkg;

  localparam int unsigned N_REQ_DEF       = 4;
  localparam int unsigned ACT_TIMEOUT_DEF = 4;

  // 27 MHz clock, 115200 baud.
  localparam int unsigned CLKS_PER_BIT    = 234;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: searches from ptr+1 upward, wrapping at N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 valid
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] idx;

  // First requester found after the pointer wins; the pointer itself is checked last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with optional grant locking for multi-byte messages and a start-handshake timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]   i_Lock,
  output logic [N_REQ-1:0]   o_Ack,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Active,
  input  logic               i_Tx_Done,
  output logic               o_Busy,
  output logic               o_Err
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(ACT_TIMEOUT + 1);
  // The ISSUE clock is the first allowed clock, so WAIT_ACT gives up
  // after ACT_TIMEOUT-1 of its own clocks.
  localparam int unsigned CNT_LAST = (ACT_TIMEOUT >= 2) ? ACT_TIMEOUT - 2 : 0;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    last_q, last_d;
  logic [7:0]       byte_q, byte_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [7:0]       pick_byte;
  logic [7:0]       own_byte;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req   (i_Req),
    .ptr   (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Index and byte of the round-robin winner, and the current owner's byte.
  always_comb begin
    pick_idx  = '0;
    pick_byte = '0;
    own_byte  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        pick_idx  = PW'(k);
        pick_byte = i_Req_Byte[8*k +: 8];
      end
      if (owner_q == PW'(k)) begin
        own_byte = i_Req_Byte[8*k +: 8];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          byte_d  = pick_byte;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (i_Tx_Active) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= CW'(CNT_LAST)) begin
          err_d   = 1'b1;
          grant_d = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for Done to fall so a long Done pulse is seen only once.
        if (!i_Tx_Done) begin
          if (i_Lock[owner_q] && i_Req[owner_q]) begin
            byte_d  = own_byte;
            state_d = ISSUE;
          end else begin
            last_d  = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    dv_d   = (state_d == ISSUE);
    ack_d  = (state_d == ISSUE) ? grant_d : '0;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any byte in flight silently.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      last_q  <= PW'(N_REQ - 1);
      byte_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Grant   = grant_q;
  assign o_Ack     = ack_q;
  assign o_Tx_DV   = dv_q;
  assign o_Tx_Byte = byte_q;
  assign o_Busy    = busy_q;
  assign o_Err     = err_q;

endmodule
